// File: rtl/adder_pkg.sv
// adder_pkg: shared encodings for the serial add/subtract unit.
// FSM state values and operating mode constants.
package adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational ripple of CHUNK full-adder cells.
// Also exposes the carry entering the top cell for overflow detection.
module addsub_chunk
   import adder_pkg::*;
#(
   parameter int CHUNK = 1
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] sum,
   output logic             co,
   output logic             cmsb
);

   always_comb begin
      logic cc;
      cc   = ci;
      sum  = '0;
      cmsb = ci;
      for (int i = 0; i < CHUNK; i++) begin
         cmsb   = cc;
         sum[i] = a[i] ^ b[i] ^ cc;
         cc     = (a[i] & b[i]) | (cc & (a[i] ^ b[i]));
      end
      co = cc;
   end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle add/subtract, CHUNK bits per cycle, LSB first.
// Subtraction is a + ~b + ~borrow, so cout=1 means no borrow.
module serial_addsub
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCH - 1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] areg, breg, sreg, s_r;
   logic [WIDTH-1:0] snext;
   logic [CW-1:0]    cnt;
   logic [CHUNK-1:0] csum;
   logic             carry, cout_r, ovf_r;
   logic             cco, cmsb;
   logic             accept, last;

   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (areg[CHUNK-1:0]),
      .b    (breg[CHUNK-1:0]),
      .ci   (carry),
      .sum  (csum),
      .co   (cco),
      .cmsb (cmsb)
   );

   assign accept = in_valid && in_ready;
   assign last   = (cnt == LAST);
   // new chunk enters at the top; after NCH shifts bit 0 is the LSB
   assign snext  = WIDTH'({csum, sreg} >> CHUNK);

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (last) state_nx = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         areg   <= '0;
         breg   <= '0;
         sreg   <= '0;
         s_r    <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            areg  <= a;
            breg  <= (sub == MODE_ADD) ? b : ~b;
            carry <= cin ^ (sub == MODE_SUB);
            cnt   <= '0;
         end else if (state == ST_RUN) begin
            areg  <= areg >> CHUNK;
            breg  <= breg >> CHUNK;
            sreg  <= snext;
            carry <= cco;
            cnt   <= cnt + CW'(1);
            if (last) begin
               s_r    <= snext;
               cout_r <= cco;
               ovf_r  <= cmsb ^ cco;
            end
         end
      end
   end

   assign s    = s_r;
   assign cout = cout_r;
   assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: randomized and directed checks against an arithmetic model.
// Covers WIDTH=8/CHUNK=1 plus exhaustive WIDTH=4 with CHUNK=2 and CHUNK=4.
module tb_serial_addsub;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready;
   logic [7:0] a8, b8, s8;
   logic       cin8, sub8;
   logic       out_valid, out_ready;
   logic       cout8, ovf8;

   logic       in_valid4, out_ready4;
   logic [3:0] a4, b4;
   logic       cin4, sub4;
   logic       rdy2, vld2, c2, o2;
   logic       rdy4, vld4, c4, o4;
   logic [3:0] s2, s4;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(8), .CHUNK(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s8), .cout(cout8), .ovf(ovf8)
   );

   serial_addsub #(.WIDTH(4), .CHUNK(2)) dut_c2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid4), .in_ready(rdy2),
      .a(a4), .b(b4), .cin(cin4), .sub(sub4),
      .out_valid(vld2), .out_ready(out_ready4),
      .s(s2), .cout(c2), .ovf(o2)
   );

   serial_addsub #(.WIDTH(4), .CHUNK(4)) dut_c4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid4), .in_ready(rdy4),
      .a(a4), .b(b4), .cin(cin4), .sub(sub4),
      .out_valid(vld4), .out_ready(out_ready4),
      .s(s4), .cout(c4), .ovf(o4)
   );

   // plain integer arithmetic: unsigned result mod 2^w, signed range test
   function automatic void model(input int w, input int ia, input int ib,
                                 input int ic, input int isub,
                                 output int es, output int ec,
                                 output int eo);
      int m, h, sa, sb, t, sr;
      m  = 1 << w;
      h  = m / 2;
      sa = (ia >= h) ? ia - m : ia;
      sb = (ib >= h) ? ib - m : ib;
      if (isub == 0) begin
         t  = ia + ib + ic;
         ec = (t >= m) ? 1 : 0;
         sr = sa + sb + ic;
      end else begin
         t  = ia - ib - ic;
         ec = (t >= 0) ? 1 : 0;
         sr = sa - sb - ic;
      end
      es = ((t % m) + m) % m;
      eo = (sr < -h || sr > h - 1) ? 1 : 0;
   endfunction

   // issue one op from IDLE at a negedge; operands scrambled after accept
   task automatic run8(input logic [7:0] ta, input logic [7:0] tb,
                       input logic tc, input logic ts,
                       output logic [7:0] rs, output logic rc,
                       output logic ro, output int lat);
      a8 = ta; b8 = tb; cin8 = tc; sub8 = ts;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      cin8 = 1'($urandom); sub8 = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      rs = s8; rc = cout8; ro = ovf8;
      if (out_ready) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, s8, cout8, ovf8} !== {1'b1, 1'b0, 8'h00, 2'b00}) begin
         fails++;
         $display("FAIL reset8 rdy=%b vld=%b s=%h c=%b v=%b want 1 0 00 0 0",
                  in_ready, out_valid, s8, cout8, ovf8);
      end
      checks++;
      if ({rdy2, vld2, s2, c2, o2, rdy4, vld4, s4, c4, o4} !==
          {1'b1, 1'b0, 4'h0, 2'b00, 1'b1, 1'b0, 4'h0, 2'b00}) begin
         fails++;
         $display("FAIL reset4 c2: %b %b %h c4: %b %b %h want 1 0 0",
                  rdy2, vld2, s2, rdy4, vld4, s4);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [7:0] ta [6] = '{8'hFF, 8'h7F, 8'h80, 8'h05, 8'h07, 8'h80};
      logic [7:0] tb [6] = '{8'h01, 8'h01, 8'hFF, 8'h07, 8'h05, 8'h01};
      logic       tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic       ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [7:0] xs [6] = '{8'h00, 8'h80, 8'h7F, 8'hFE, 8'h01, 8'h7F};
      logic       xc [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic       xo [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [7:0] rs;
      logic       rc, ro;
      int         lat;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         run8(ta[i], tb[i], tc[i], ts[i], rs, rc, ro, lat);
         checks++;
         if ({rs, rc, ro} !== {xs[i], xc[i], xo[i]}) begin
            fails++;
            $display("FAIL directed%0d got s=%h c=%b v=%b want s=%h c=%b v=%b",
                     i, rs, rc, ro, xs[i], xc[i], xo[i]);
         end
         checks++;
         if (lat !== 8) begin
            fails++;
            $display("FAIL latency%0d got %0d want 8", i, lat);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] ta, tb, rs;
      logic       tc, ts, rc, ro;
      int         es, ec, eo, lat;
      logic [7:0] es8;
      out_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         ta = 8'($urandom); tb = 8'($urandom);
         tc = 1'($urandom); ts = 1'($urandom);
         model(8, int'(ta), int'(tb), int'(tc), int'(ts), es, ec, eo);
         es8 = es[7:0];
         run8(ta, tb, tc, ts, rs, rc, ro, lat);
         checks++;
         if ({rs, rc, ro, lat} !== {es8, ec[0], eo[0], 32'd8}) begin
            fails++;
            $display("FAIL random a=%h b=%h ci=%b sub=%b got s=%h c=%b v=%b lat=%0d want s=%h c=%0d v=%0d lat=8",
                     ta, tb, tc, ts, rs, rc, ro, lat, es8, ec, eo);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ta, tb, rs;
      logic       rc, ro;
      int         es, ec, eo, lat;
      logic [7:0] es8;
      time        t0, t1;
      out_ready = 1'b1;
      t0 = $time;
      for (int i = 0; i < 4; i++) begin
         ta = 8'($urandom); tb = 8'($urandom);
         model(8, int'(ta), int'(tb), 0, 1, es, ec, eo);
         es8 = es[7:0];
         run8(ta, tb, 1'b0, 1'b1, rs, rc, ro, lat);
         t1 = $time;
         checks++;
         if ({rs, rc, ro} !== {es8, ec[0], eo[0]}) begin
            fails++;
            $display("FAIL b2b_result%0d got s=%h c=%b v=%b want s=%h c=%0d v=%0d",
                     i, rs, rc, ro, es8, ec, eo);
         end
         checks++;
         if (t1 - t0 !== 100) begin
            fails++;
            $display("FAIL b2b_period%0d got %0t want 100", i, t1 - t0);
         end
         t0 = t1;
      end
   endtask

   task automatic test_backpressure();
      int         es, ec, eo, lat;
      logic [7:0] es8;
      int         bad;
      model(8, 8'h3C, 8'h5A, 1, 0, es, ec, eo);
      es8 = es[7:0];
      out_ready = 1'b0;
      a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b1; sub8 = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lat = 0;
      while (!out_valid && lat < 40) begin
         a8 = 8'($urandom); b8 = 8'($urandom);
         sub8 = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      checks++;
      if ({s8, cout8, ovf8, lat} !== {es8, ec[0], eo[0], 32'd8}) begin
         fails++;
         $display("FAIL bp_result got s=%h c=%b v=%b lat=%0d want s=%h c=%0d v=%0d lat=8",
                  s8, cout8, ovf8, lat, es8, ec, eo);
      end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a8 = 8'($urandom);
         if (!out_valid || in_ready || s8 !== es8) bad++;
      end
      checks++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL bp_hold got %0d bad cycles want 0 (vld=%b rdy=%b s=%h)",
                  bad, out_valid, in_ready, s8);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, s8, cout8, ovf8} !== {2'b01, es8, ec[0], eo[0]}) begin
         fails++;
         $display("FAIL bp_release got vld=%b rdy=%b s=%h want 0 1 %h",
                  out_valid, in_ready, s8, es8);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [7:0] rs;
      logic       rc, ro;
      int         lat, pulses, es, ec, eo;
      out_ready = 1'b1;
      run8(8'h12, 8'h34, 1'b0, 1'b0, rs, rc, ro, lat);
      checks++;
      if (rs !== 8'h46) begin
         fails++;
         $display("FAIL pre_rst got s=%h want 46", rs);
      end
      a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; sub8 = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({in_ready, out_valid, s8, cout8, ovf8} !== {2'b10, 8'h00, 2'b00}) begin
         fails++;
         $display("FAIL mid_rst got rdy=%b vld=%b s=%h c=%b v=%b want 1 0 00 0 0",
                  in_ready, out_valid, s8, cout8, ovf8);
      end
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         fails++;
         $display("FAIL rst_no_pulse got %0d want 0", pulses);
      end
      model(8, 8'hA5, 8'h5A, 1, 1, es, ec, eo);
      run8(8'hA5, 8'h5A, 1'b1, 1'b1, rs, rc, ro, lat);
      checks++;
      if ({rs, rc, ro} !== {es[7:0], ec[0], eo[0]}) begin
         fails++;
         $display("FAIL post_rst got s=%h c=%b v=%b want s=%h c=%0d v=%0d",
                  rs, rc, ro, es[7:0], ec, eo);
      end
   endtask

   task automatic test_exhaustive_w4();
      int         es, ec, eo, l2, l4, nbad;
      logic [5:0] exp6, got2, got4;
      nbad = 0;
      out_ready4 = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         a4 = 4'(i); b4 = 4'(i >> 4);
         cin4 = 1'(i >> 8); sub4 = 1'(i >> 9);
         model(4, i & 15, (i >> 4) & 15, (i >> 8) & 1, (i >> 9) & 1,
               es, ec, eo);
         exp6 = {es[3:0], ec[0], eo[0]};
         in_valid4 = 1'b1;
         @(posedge clk);
         @(negedge clk);
         in_valid4 = 1'b0;
         a4 = 4'($urandom); b4 = 4'($urandom);
         l2 = -1; l4 = -1;
         got2 = '0; got4 = '0;
         for (int k = 0; k < 10 && (l2 < 0 || l4 < 0); k++) begin
            if (vld2 && l2 < 0) begin l2 = k; got2 = {s2, c2, o2}; end
            if (vld4 && l4 < 0) begin l4 = k; got4 = {s4, c4, o4}; end
            @(negedge clk);
         end
         @(negedge clk);
         checks++;
         if (got2 !== exp6 || l2 !== 2 || got4 !== exp6 || l4 !== 1) begin
            fails++;
            nbad++;
            if (nbad < 10)
               $display("FAIL w4 op=%0d c2=%h/lat%0d c4=%h/lat%0d want %h/lat2,lat1",
                        i, got2, l2, got4, l4, exp6);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1;
      a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
      in_valid4 = 1'b0; out_ready4 = 1'b1;
      a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_op();
      test_exhaustive_w4();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
